// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: WIDTH-bit add/subtract that resolves CHUNK bits per pipeline stage.
// The carry is registered between slices, and one global advance signal provides valid/ready flow control.
module pipelined_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_param_check
    $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv_s;

  // Stage registers: a/b carry the unresolved upper slices, s holds the resolved lower slices.
  logic [WIDTH-1:0] a_r   [NCHUNK];
  logic [WIDTH-1:0] b_r   [NCHUNK];
  logic [WIDTH-1:0] s_r   [NCHUNK];
  logic             c_r   [NCHUNK];
  logic             v_r   [NCHUNK];
  logic             ovf_r;

  logic [WIDTH-1:0] a_in_s  [NCHUNK];
  logic [WIDTH-1:0] b_in_s  [NCHUNK];
  logic [WIDTH-1:0] s_in_s  [NCHUNK];
  logic             c_in_s  [NCHUNK];
  logic             v_in_s  [NCHUNK];
  logic [CHUNK:0]   slice_s [NCHUNK];
  logic [WIDTH-1:0] s_nxt_s [NCHUNK];
  logic             c_nxt_s [NCHUNK];
  logic             ovf_nxt_s;

  assign adv_s     = !v_r[NCHUNK-1] || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = v_r[NCHUNK-1];
  assign sum       = s_r[NCHUNK-1];
  assign cout      = c_r[NCHUNK-1];
  assign ovf       = ovf_r;

  // Stage inputs: stage 0 takes the live operands; stage k takes stage k-1's registers.
  always_comb begin
    a_in_s[0] = a;
    b_in_s[0] = sub ? ~b : b;
    c_in_s[0] = sub ? 1'b1 : cin;
    s_in_s[0] = {WIDTH{1'b0}};
    v_in_s[0] = in_valid;
    for (int k = 1; k < NCHUNK; k++) begin
      a_in_s[k] = a_r[k-1];
      b_in_s[k] = b_r[k-1];
      c_in_s[k] = c_r[k-1];
      s_in_s[k] = s_r[k-1];
      v_in_s[k] = v_r[k-1];
    end
  end

  // Per-stage slice addition: resolve slice k and splice it into the partial sum.
  always_comb begin
    for (int k = 0; k < NCHUNK; k++) begin
      slice_s[k] = {1'b0, a_in_s[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_in_s[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_in_s[k]};
      s_nxt_s[k] = s_in_s[k];
      s_nxt_s[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
      c_nxt_s[k] = slice_s[k][CHUNK];
    end
  end

  // Signed overflow: carry into the MSB (recovered as sum^a^b at the MSB) xor carry out.
  always_comb begin
    ovf_nxt_s = s_nxt_s[NCHUNK-1][WIDTH-1]
              ^ a_in_s[NCHUNK-1][WIDTH-1]
              ^ b_in_s[NCHUNK-1][WIDTH-1]
              ^ c_nxt_s[NCHUNK-1];
  end

  // Pipeline registers: reset wins; otherwise all stages shift together on adv.
  // Data loads only with a valid beat, so the outputs change only when a new result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCHUNK; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        s_r[k] <= {WIDTH{1'b0}};
        c_r[k] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < NCHUNK; k++) begin
        v_r[k] <= v_in_s[k];
        if (v_in_s[k]) begin
          a_r[k] <= a_in_s[k];
          b_r[k] <= b_in_s[k];
          s_r[k] <= s_nxt_s[k];
          c_r[k] <= c_nxt_s[k];
        end
      end
      if (v_in_s[NCHUNK-1]) begin
        ovf_r <= ovf_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Testbench for pipelined_chunk_adder. It drives an 8/4 instance and a 32/8 instance.
// Expected results are computed from the operands, queued on acceptance, and compared on retirement.
module tb_pipelined_chunk_adder;
  logic clk = 1'b0;
  logic rst;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  int errors = 0;
  int checks = 0;
  logic [33:0] q8[$];
  logic [33:0] q32[$];
  logic acc8;
  logic [33:0] held;
  logic [33:0] e;
  int j;

  always #5 clk = ~clk;

  pipelined_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  // Returns {ovf, cout, sum[31:0]} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [63:0] mask, xe, ye, tot;
    logic [31:0] s;
    logic        v;
    mask = (64'd1 << w) - 64'd1;
    xe   = {32'd0, x} & mask;
    ye   = sb ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    tot  = xe + ye + (sb ? 64'd1 : {63'd0, ci});
    s    = tot[31:0] & mask[31:0];
    v    = (xe[w-1] == ye[w-1]) && (s[w-1] != xe[w-1]);
    return {v, tot[w], s};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard push/pop at the negedge, then return just after the posedge.
  task automatic tick();
    @(negedge clk);
    acc8 = 1'b0;
    if (rst) begin
      q8.delete();
      q32.delete();
    end else begin
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) chk("unexpected_out8", {ovf8, cout8, 24'd0, sum8}, 34'd0);
        else begin
          e = q8.pop_front();
          chk("result8", {ovf8, cout8, 24'd0, sum8}, e);
        end
      end
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) chk("unexpected_out32", {ovf32, cout32, sum32}, 34'd0);
        else begin
          e = q32.pop_front();
          chk("result32", {ovf32, cout32, sum32}, e);
        end
      end
      if (in_valid8 && in_ready8) begin
        q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8));
        acc8 = 1'b1;
      end
      if (in_valid32 && in_ready32) q32.push_back(model(32, a32, b32, cin32, sub32));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
    in_valid8 = 1'b1; a8 = x; b8 = y; cin8 = ci; sub8 = sb;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid8", {33'd0, out_valid8}, 34'd0);
    chk("reset_result8", {ovf8, cout8, 24'd0, sum8}, 34'd0);
    chk("reset_in_ready8", {33'd0, in_ready8}, 34'd1);
    chk("reset_out_valid32", {33'd0, out_valid32}, 34'd0);
    chk("reset_result32", {ovf32, cout32, sum32}, 34'd0);

    // Single beat FF+01: latency 2, carry ripples across the slice boundary.
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    in_valid8 = 1'b0;
    chk("latency_not_yet", {33'd0, out_valid8}, 34'd0);
    tick();
    chk("latency_valid", {33'd0, out_valid8}, 34'd1);
    chk("ff_plus_01", {ovf8, cout8, 24'd0, sum8}, {1'b0, 1'b1, 32'h0000_0000});
    tick();

    // Overflow and subtract vectors, back to back.
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
    send8(8'h80, 8'hFF, 1'b0, 1'b0);
    chk("ovf_7f_01", {ovf8, cout8, 24'd0, sum8}, {1'b1, 1'b0, 32'h0000_0080});
    send8(8'h05, 8'h07, 1'b1, 1'b1);
    chk("ovf_80_ff", {ovf8, cout8, 24'd0, sum8}, {1'b1, 1'b1, 32'h0000_007F});
    send8(8'h07, 8'h05, 1'b0, 1'b1);
    chk("sub_05_07", {ovf8, cout8, 24'd0, sum8}, {1'b0, 1'b0, 32'h0000_00FE});
    in_valid8 = 1'b0;
    tick();
    chk("sub_07_05", {ovf8, cout8, 24'd0, sum8}, {1'b0, 1'b1, 32'h0000_0002});
    repeat (3) tick();
    chk("drain_vectors", 34'(q8.size()), 34'd0);

    // Streaming: 16 back-to-back beats, results must come out with no gaps.
    for (int i = 0; i < 16; i++) begin
      send8(8'(i), 8'(3 * i), 1'b0, 1'b0);
      if (i >= 1) chk("stream_no_gap", {33'd0, out_valid8}, 34'd1);
    end
    in_valid8 = 1'b0;
    tick();
    chk("stream_last_valid", {33'd0, out_valid8}, 34'd1);
    tick();
    chk("stream_empty", {33'd0, out_valid8}, 34'd0);
    chk("stream_drained", 34'(q8.size()), 34'd0);

    // Backpressure: stall the consumer for 5 cycles while the source keeps offering.
    j = 0;
    in_valid8 = 1'b1; cin8 = 1'b0; sub8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'(j * 7 + 1); b8 = 8'(j * 13);
      tick();
      if (acc8) j++;
    end
    a8 = 8'(j * 7 + 1); b8 = 8'(j * 13);
    out_ready8 = 1'b0;
    #1;
    chk("stall_in_ready", {33'd0, in_ready8}, 34'd0);
    held = {ovf8, cout8, 24'd0, sum8};
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc8) j++;
      chk("stall_in_ready_hold", {33'd0, in_ready8}, 34'd0);
      chk("stall_valid_hold", {33'd0, out_valid8}, 34'd1);
      chk("stall_sum_stable", {ovf8, cout8, 24'd0, sum8}, held);
    end
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'(j * 7 + 1); b8 = 8'(j * 13);
      tick();
      if (acc8) j++;
    end
    in_valid8 = 1'b0;
    repeat (4) tick();
    chk("stall_beats_accepted", 34'(j), 34'd8);
    chk("stall_drained", 34'(q8.size()), 34'd0);

    // Reset with two beats in flight on the 32-bit instance.
    in_valid32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1111_1111;
    tick();
    a32 = 32'h0000_00FF; b32 = 32'h0000_0001;
    tick();
    in_valid32 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_flush_valid", {33'd0, out_valid32}, 34'd0);
    chk("rst_flush_result", {ovf32, cout32, sum32}, 34'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_stale", {33'd0, out_valid32}, 34'd0);
    end
    in_valid32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0;
    tick();
    in_valid32 = 1'b0;
    tick();
    tick();
    chk("w32_latency_not_yet", {33'd0, out_valid32}, 34'd0);
    tick();
    chk("w32_latency_valid", {33'd0, out_valid32}, 34'd1);
    chk("w32_wrap", {ovf32, cout32, sum32}, {1'b0, 1'b1, 32'h0000_0000});
    tick();
    chk("w32_drained", 34'(q32.size()), 34'd0);

    // Mixed random traffic with random backpressure on both instances.
    for (int i = 0; i < 60; i++) begin
      in_valid8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      out_ready8 = ($urandom_range(0, 3) != 0);
      in_valid32 = 1'($urandom_range(0, 1)); a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      out_ready32 = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid8 = 1'b0; in_valid32 = 1'b0; out_ready8 = 1'b1; out_ready32 = 1'b1;
    repeat (12) tick();
    chk("random_drained8", 34'(q8.size()), 34'd0);
    chk("random_drained32", 34'(q32.size()), 34'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
